// File: rtl/gcd_lcm_engine_pkg.sv
// Shared definitions for the GCD/LCM coprocessor.
// Holds the operation select encoding, the engine state encoding and the
// custom-instruction opcodes that the main decoder also uses for dispatch.
`timescale 1ns/1ps
package copro_pkg;

  typedef enum logic {
    FUNC_GCD = 1'b0,
    FUNC_LCM = 1'b1
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [6:0] OP_GCD = 7'b0000000;
  localparam logic [6:0] OP_LCM = 7'b0000001;

endpackage

// File: rtl/gcd_lcm_engine_if.sv
// Handshake bundle between the core (master) and the GCD/LCM engine (slave).
//   start/func/a/b/abort : request side, driven by the core
//   ready/busy           : engine idle / operation in flight
//   done/result          : one-cycle completion pulse and held result
//   overflow/timeout     : completion flags, valid with done
`timescale 1ns/1ps
interface gcd_lcm_engine_if #(
  parameter int WIDTH = 32
);
  import copro_pkg::*;

  logic             start;
  func_e            func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             timeout;

  modport master (
    output start, func, a, b, abort,
    input  ready, busy, done, result, overflow, timeout
  );

  modport slave (
    input  start, func, a, b, abort,
    output ready, busy, done, result, overflow, timeout
  );

endinterface

// File: rtl/gcd_lcm_engine_step.sv
// Combinational single-iteration datapath for the GCD/LCM engine.
//   func          : operation select
//   m, n          : current working values
//   a, b          : original operands (LCM increments)
//   m_next/n_next : working values after one step
//   eq            : m == n (operation has converged)
//   carry         : LCM increment carried out of WIDTH bits
`timescale 1ns/1ps
module gcd_lcm_step
  import copro_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  func_e            func,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] m_next,
  output logic [WIDTH-1:0] n_next,
  output logic             eq,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    m_next = m;
    n_next = n;
    sum    = '0;
    carry  = 1'b0;
    eq     = (m == n);
    if (func == FUNC_GCD) begin
      if (m > n) m_next = m - n;
      else       n_next = n - m;
    end else begin
      // Advance whichever running multiple is behind.
      if (m < n) begin
        sum    = {1'b0, m} + {1'b0, a};
        m_next = sum[WIDTH-1:0];
      end else begin
        sum    = {1'b0, n} + {1'b0, b};
        n_next = sum[WIDTH-1:0];
      end
      carry = sum[WIDTH];
    end
  end

endmodule

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle GCD/LCM coprocessor engine.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of the start/ready/done handshake
// One subtract (GCD) or add (LCM) step per cycle in RUN; finishes on
// convergence, zero operand, iteration bound or LCM overflow.
`timescale 1ns/1ps
module gcd_lcm_engine
  import copro_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              reset,
  gcd_lcm_engine_if.slave   bus
);

  localparam int             CW      = $clog2(MAX_ITER + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_ITER);

  state_e           state;
  func_e            func_r;
  logic [WIDTH-1:0] m, n, a_r, b_r;
  logic [CW-1:0]    cnt;
  logic             zero;
  logic             done_r, overflow_r, timeout_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH-1:0] m_next, n_next;
  logic             eq, carry;

  gcd_lcm_step #(.WIDTH(WIDTH)) u_step (
    .func   (func_r),
    .m      (m),
    .n      (n),
    .a      (a_r),
    .b      (b_r),
    .m_next (m_next),
    .n_next (n_next),
    .eq     (eq),
    .carry  (carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      func_r     <= FUNC_GCD;
      m          <= '0;
      n          <= '0;
      a_r        <= '0;
      b_r        <= '0;
      cnt        <= '0;
      zero       <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
      result_r   <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m          <= bus.a;
            n          <= bus.b;
            a_r        <= bus.a;
            b_r        <= bus.b;
            func_r     <= bus.func;
            cnt        <= '0;
            zero       <= (bus.a == '0) || (bus.b == '0);
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (zero) begin
            result_r <= (func_r == FUNC_GCD) ? (a_r | b_r) : '0;
            done_r   <= 1'b1;
            state    <= IDLE;
          end else if (eq) begin
            result_r <= m;
            done_r   <= 1'b1;
            state    <= IDLE;
          end else if (cnt == MAX_CNT) begin
            result_r  <= '0;
            timeout_r <= 1'b1;
            done_r    <= 1'b1;
            state     <= IDLE;
          end else if (carry) begin
            result_r   <= '0;
            overflow_r <= 1'b1;
            done_r     <= 1'b1;
            state      <= IDLE;
          end else begin
            m   <= m_next;
            n   <= n_next;
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.overflow = overflow_r;
  assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed bench for gcd_lcm_engine: a 32-bit instance with the default
// iteration bound and an 8-bit instance with MAX_ITER=16.
`timescale 1ns/1ps
module tb_gcd_lcm_engine;
  import copro_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gcd_lcm_engine_if #(.WIDTH(32)) b32 ();
  gcd_lcm_engine_if #(.WIDTH(8))  b8  ();

  gcd_lcm_engine #(.WIDTH(32), .MAX_ITER(65535)) u32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  gcd_lcm_engine #(.WIDTH(8), .MAX_ITER(16)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_result(input int sel);
    return (sel == 0) ? b32.result : {24'h0, b8.result};
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel == 0) ? b32.done : b8.done;
  endfunction
  function automatic logic rd_ready(input int sel);
    return (sel == 0) ? b32.ready : b8.ready;
  endfunction
  function automatic logic rd_busy(input int sel);
    return (sel == 0) ? b32.busy : b8.busy;
  endfunction
  function automatic logic rd_ov(input int sel);
    return (sel == 0) ? b32.overflow : b8.overflow;
  endfunction
  function automatic logic rd_to(input int sel);
    return (sel == 0) ? b32.timeout : b8.timeout;
  endfunction

  task automatic drive(input int sel, input logic s, input func_e f,
                       input logic [31:0] x, input logic [31:0] y);
    if (sel == 0) begin
      b32.start = s; b32.func = f; b32.a = x; b32.b = y;
    end else begin
      b8.start = s; b8.func = f; b8.a = x[7:0]; b8.b = y[7:0];
    end
  endtask

  task automatic check_reset(input string tag, input int sel);
    check({tag, "_ready"},  32'(rd_ready(sel)), 32'd1);
    check({tag, "_busy"},   32'(rd_busy(sel)),  32'd0);
    check({tag, "_done"},   32'(rd_done(sel)),  32'd0);
    check({tag, "_result"}, rd_result(sel),     32'd0);
    check({tag, "_ovf"},    32'(rd_ov(sel)),    32'd0);
    check({tag, "_tmo"},    32'(rd_to(sel)),    32'd0);
  endtask

  // Launch, then measure edges after the accepting edge until done.
  // Returns #1 after the finishing edge, i.e. inside the done cycle.
  task automatic run_op(input string tag, input int sel, input func_e f,
                        input logic [31:0] x, input logic [31:0] y,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ov, input logic exp_to);
    int lat;
    lat = 0;
    drive(sel, 1'b1, f, x, y);
    tick(1);
    drive(sel, 1'b0, f, x, y);
    check({tag, "_busy"},     32'(rd_busy(sel)),  32'd1);
    check({tag, "_ready"},    32'(rd_ready(sel)), 32'd0);
    check({tag, "_ovf_clr"},  32'(rd_ov(sel)),    32'd0);
    check({tag, "_tmo_clr"},  32'(rd_to(sel)),    32'd0);
    do begin
      tick(1);
      lat++;
    end while (!rd_done(sel) && lat < 200);
    check({tag, "_latency"}, 32'(lat),          32'(exp_lat));
    check({tag, "_result"},  rd_result(sel),    exp_res);
    check({tag, "_ovf"},     32'(rd_ov(sel)),   32'(exp_ov));
    check({tag, "_tmo"},     32'(rd_to(sel)),   32'(exp_to));
    check({tag, "_rdy_done"}, 32'(rd_ready(sel)), 32'd1);
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    b32.start = 1'b0; b32.func = FUNC_GCD; b32.a = '0; b32.b = '0; b32.abort = 1'b0;
    b8.start  = 1'b0; b8.func  = FUNC_GCD; b8.a  = '0; b8.b  = '0; b8.abort  = 1'b0;
    tick(2);
    reset = 1'b0;
    check_reset("rst32", 0);
    check_reset("rst8", 1);

    // gcd(12,8): second start while busy must be dropped.
    drive(0, 1'b1, FUNC_GCD, 32'd12, 32'd8);
    tick(1);                                   // E0
    drive(0, 1'b0, FUNC_GCD, 32'd12, 32'd8);
    check("gcd12_busy", 32'(b32.busy), 32'd1);
    tick(1);                                   // E1
    drive(0, 1'b1, FUNC_GCD, 32'd9, 32'd3);
    tick(1);                                   // E2 ignores start
    drive(0, 1'b0, FUNC_GCD, 32'd9, 32'd3);
    check("gcd12_done_e2", 32'(b32.done), 32'd0);
    tick(1);                                   // E3
    check("gcd12_done_e3", 32'(b32.done),     32'd1);
    check("gcd12_result",  b32.result,        32'd4);
    check("gcd12_flags",   {b32.overflow, b32.timeout}, 32'd0);
    tick(1);
    check("gcd12_pulse",   32'(b32.done),     32'd0);
    check("gcd12_noqueue", 32'(b32.ready),    32'd1);

    // lcm(4,6), then a start issued in the done cycle.
    run_op("lcm4_6",  0, FUNC_LCM, 32'd4,  32'd6,  4, 32'd12, 1'b0, 1'b0);
    run_op("gcd21_14", 0, FUNC_GCD, 32'd21, 32'd14, 3, 32'd7,  1'b0, 1'b0);

    // Zero operands.
    run_op("gcd0_9", 0, FUNC_GCD, 32'd0, 32'd9, 1, 32'd9, 1'b0, 1'b0);
    run_op("gcd0_0", 0, FUNC_GCD, 32'd0, 32'd0, 1, 32'd0, 1'b0, 1'b0);
    run_op("lcm0_9", 0, FUNC_LCM, 32'd0, 32'd9, 1, 32'd0, 1'b0, 1'b0);
    run_op("gcd32_full", 0, FUNC_GCD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // 8-bit overflow: 254+254 carries out on the first step.
    run_op("lcm255_254", 1, FUNC_LCM, 32'd255, 32'd254, 1, 32'd0, 1'b1, 1'b0);
    tick(1);
    check("ovf_pulse_once", 32'(b8.done), 32'd0);
    check("ovf_held",       32'(b8.overflow), 32'd1);
    run_op("gcd6_4_a", 1, FUNC_GCD, 32'd6, 32'd4, 3, 32'd2, 1'b0, 1'b0);

    // Timeout at MAX_ITER=16.
    run_op("gcd100_1_tmo", 1, FUNC_GCD, 32'd100, 32'd1, 17, 32'd0, 1'b0, 1'b1);
    run_op("gcd9_6", 1, FUNC_GCD, 32'd9, 32'd6, 3, 32'd3, 1'b0, 1'b0);

    // Abort two cycles into gcd(100,1).
    drive(1, 1'b1, FUNC_GCD, 32'd100, 32'd1);
    tick(1);                                   // E0
    drive(1, 1'b0, FUNC_GCD, 32'd100, 32'd1);
    tick(1);                                   // E1
    check("abort_busy", 32'(b8.busy), 32'd1);
    b8.abort = 1'b1;
    tick(1);                                   // E2
    b8.abort = 1'b0;
    check("abort_ready",  32'(b8.ready), 32'd1);
    check("abort_result", {24'h0, b8.result}, 32'd3);
    nd = 0;
    repeat (20) begin
      tick(1);
      if (b8.done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_result_held", {24'h0, b8.result}, 32'd3);

    // Asynchronous reset mid-operation.
    drive(1, 1'b1, FUNC_GCD, 32'd100, 32'd1);
    tick(1);
    drive(1, 1'b0, FUNC_GCD, 32'd100, 32'd1);
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset("arst8", 1);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (20) begin
      tick(1);
      if (b8.done) nd++;
    end
    check("arst_no_done", 32'(nd), 32'd0);
    run_op("gcd6_4_b", 1, FUNC_GCD, 32'd6, 32'd4, 3, 32'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_lcm_engine.md
# gcd_lcm_engine

Parametrised multi-cycle GCD/LCM coprocessor engine. The core's decoder dispatches the custom GCD (opcode 7'b0000000) and LCM (opcode 7'b0000001) instructions to it through a start/ready/done handshake, and the core stalls on `busy` until writeback. Operand width and iteration bound are parametric. New relative to the single-cycle decode path: overflow detection, an iteration timeout, and pipeline-flush abort.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 4).
- `MAX_ITER`, 65535, maximum step iterations before timeout abort (≥ 1).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `func`  in  1  0 = GCD, 1 = LCM (values from package enum).
- `a`, `b`  in  WIDTH each  unsigned operands, sampled on the accepting edge.
- `abort`  in  1  pipeline flush; cancels an operation in flight.
- `ready`  out  1  engine idle and able to accept `start`.
- `busy`  out  1  operation in flight; equals `!ready`.
- `done`  out  1  one-cycle pulse; `result` and flags valid.
- `result`  out  WIDTH  last result; held until the next `done`.
- `overflow`  out  1  LCM exceeded WIDTH bits; valid with `done`.
- `timeout`  out  1  MAX_ITER reached; valid with `done`.

## Operation
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, `overflow`=0, `timeout`=0. Internal registers m, n, iteration counter and zero flag are all 0.
- FSM states: IDLE and RUN.
- IDLE:
  - On `start` & `ready`: load m←a, n←b, save func, clear counter, set zero flag = (a==0 | b==0), go to RUN.
  - `abort` in IDLE is ignored.
- RUN, one step per cycle, with priority in this order:
  - `abort`: go to IDLE. No `done`; `result` and flags are unchanged.
  - Zero flag set: finish with result = GCD ? (a|b) : 0. This gives gcd(0,x)=x, gcd(0,0)=0, lcm(0,x)=0.
  - m==n: finish with result = m.
  - counter == MAX_ITER: finish with result = 0, `timeout`=1.
  - GCD step: if m>n then m←m−n, else n←n−m.
  - LCM step: if m<n then m←m+a, else n←n+b, with a and b held in operand registers. If the add carries out of WIDTH, finish with result = 0, `overflow`=1.
  - Every step that does not finish increments the counter.
- Finish: register `result` and flags, pulse `done` for the following cycle, return to IDLE.
- Flags are cleared on every accepted `start`.
- `start` while `busy` is ignored and is not queued.
- `start` in the same cycle as `done` is accepted, because the engine is already in IDLE.

## Timing
- Accepting edge E0. For N non-finishing steps, `done` is high in the cycle after edge E0+N+1. Zero operands and a==b give N=0, so `done` follows edge E1.
- `ready` is combinational from state. It is low from E0 until the finishing edge.
- Timeout latency: MAX_ITER+1 edges after E0.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at their reset values. No `done`.
- Outputs are registered except `ready` and `busy`.

## Structure
- `copro_pkg` holds:
  - `func_e` (FUNC_GCD=1'b0, FUNC_LCM=1'b1)
  - `state_e` (IDLE, RUN)
  - opcode constants OP_GCD=7'b0000000 and OP_LCM=7'b0000001, shared with the main decoder.
- One sub-module, `gcd_lcm_step`. It is purely combinational (func, m, n, a, b → next m, next n, eq, carry). The FSM, counter and registers stay in `gcd_lcm_engine`.
- Counter width is $clog2(MAX_ITER+1).

## Test plan
- GCD, WIDTH=32: a=12, b=8 → `done` after E3 with result=4, no flags. While busy, a second `start` (a=9, b=3) is ignored.
- LCM: a=4, b=6 → steps (8,6), (8,12), (12,12) → `done` after E4 with result=12. A back-to-back `start` in the `done` cycle (GCD 21,14) → result=7.
- Zero operands: gcd(0,9)=9, gcd(0,0)=0, lcm(0,9)=0, each with `done` after E1.
- Overflow, WIDTH=8: lcm(255,254) → `overflow`=1, result=0, `done` pulses once. The next accepted `start` clears `overflow`.
- Timeout, MAX_ITER=16: gcd(100,1) → `timeout`=1, result=0, `done` after E17.
- Abort and reset: assert `abort` two cycles into gcd(100,1) → IDLE, no `done`, `result` keeps its previous value. Repeat the operation with `reset` instead → all outputs return to reset values, and a new gcd(6,4) afterwards returns 2.
